// File: rtl/dmem_hs.sv
// Handshaked data memory: byte/half/word/dword loads and stores with little-endian lanes,
// configurable wait states, and error responses for misaligned, oversized or out-of-range accesses.
module dmem_hs #(
   parameter int DW    = 32,
   parameter int DEPTH = 64,
   parameter int AW    = 32,
   parameter int WAIT  = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [1:0]    req_size,
   input  logic          req_unsigned,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err
);
   localparam int NB = DW / 8;
   localparam int LB = $clog2(NB);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SW = $clog2(DW);
   localparam logic [3:0] WAIT_M1 = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]    state;
   logic [3:0]    cnt;
   logic          l_we;
   logic          l_unsigned;
   logic [1:0]    l_size;
   logic [AW-1:0] l_addr;
   logic [DW-1:0] l_wdata;

   logic          a_we;
   logic          a_unsigned;
   logic [1:0]    a_size;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_wdata;
   logic          go_resp;
   logic [LB-1:0] a_off;
   logic [AW-1:0] a_word;
   logic [IW-1:0] a_idx;
   logic [3:0]    size_bytes;
   logic [3:0]    align_mask;
   logic          a_err;

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rd_word;
   logic [DW-1:0] rd_shift;
   logic [DW-1:0] rd_ext;
   logic [DW-1:0] wr_shift;
   logic [NB-1:0] wr_be;
   logic [6:0]    n_bits;
   logic [SW-1:0] top_pos;
   logic          fill;

   assign req_ready = (state == S_IDLE);
   assign rsp_valid = (state == S_RESP);

   // With no wait states the access happens on the accept edge, so it must use the live request.
   always_comb begin
      if (state == S_IDLE) begin
         a_we       = req_we;
         a_unsigned = req_unsigned;
         a_size     = req_size;
         a_addr     = req_addr;
         a_wdata    = req_wdata;
      end else begin
         a_we       = l_we;
         a_unsigned = l_unsigned;
         a_size     = l_size;
         a_addr     = l_addr;
         a_wdata    = l_wdata;
      end
   end

   assign go_resp = ((state == S_IDLE) && req_valid && (WAIT == 0)) ||
                    ((state == S_WAIT) && (cnt == 4'd0));

   assign a_off      = a_addr[LB-1:0];
   assign a_word     = a_addr >> LB;
   assign a_idx      = a_word[IW-1:0];
   assign size_bytes = 4'd1 << a_size;
   assign align_mask = size_bytes - 4'd1;
   assign a_err      = (size_bytes > 4'(NB)) ||
                       ((4'(a_off) & align_mask) != 4'd0) ||
                       (a_word >= AW'(DEPTH));

   always_comb begin
      wr_shift = a_wdata << {a_off, 3'b000};
      wr_be    = '0;
      for (int b = 0; b < NB; b++) begin
         wr_be[b] = (b >= int'(a_off)) && (b < int'(a_off) + int'(size_bytes));
      end
   end

   always_ff @(posedge clk) begin
      if (go_resp && a_we && !a_err) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) begin
               mem[a_idx][b*8 +: 8] <= wr_shift[b*8 +: 8];
            end
         end
      end
   end

   assign rd_word  = mem[a_idx];
   assign rd_shift = rd_word >> {a_off, 3'b000};
   assign n_bits   = 7'd8 << a_size;
   assign top_pos  = SW'(n_bits - 7'd1);
   assign fill     = a_unsigned ? 1'b0 : rd_shift[top_pos];

   // Bits beyond the access width take the extension bit; a full-width access never reaches fill.
   generate
      for (genvar gi = 0; gi < DW; gi++) begin : g_ext
         assign rd_ext[gi] = (7'(gi) < n_bits) ? rd_shift[gi] : fill;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= 4'd0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         l_we       <= 1'b0;
         l_unsigned <= 1'b0;
         l_size     <= 2'd0;
         l_addr     <= '0;
         l_wdata    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  l_we       <= req_we;
                  l_unsigned <= req_unsigned;
                  l_size     <= req_size;
                  l_addr     <= req_addr;
                  l_wdata    <= req_wdata;
                  if (WAIT == 0) begin
                     state <= S_RESP;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= WAIT_M1;
                  end
               end
            end
            S_WAIT: begin
               if (cnt == 4'd0) begin
                  state <= S_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
         if (go_resp) begin
            rsp_rdata <= (a_we || a_err) ? '0 : rd_ext;
            rsp_err   <= a_err;
         end
      end
   end
endmodule

// File: tb/tb_dmem_hs.sv
// Bench for dmem_hs: three instances (32-bit/no wait, 64-bit/3 waits, 32-bit/2 waits) checked
// every cycle against a byte-addressed model, plus hand-computed expectations per transaction.
module tb_dmem_hs;
   localparam int DWV [3] = '{32, 64, 32};
   localparam int WTV [3] = '{0, 3, 2};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  req_valid, req_we, req_unsigned, rsp_ready;
   logic [2:0]  req_ready, rsp_valid, rsp_err;
   logic [1:0]  req_size [3];
   logic [31:0] req_addr [3];
   logic [63:0] req_wdata [3];
   logic [31:0] rd0, rd2;
   logic [63:0] rd1;

   int checks = 0;
   int failures = 0;

   // model: phase 0 idle, 1 waiting, 2 responding
   int          ph [3];
   int          rem [3];
   logic [2:0]  l_we, l_uns;
   logic [1:0]  l_size [3];
   logic [31:0] l_addr [3];
   logic [63:0] l_wdata [3];
   logic [63:0] exp_rd [3];
   logic [2:0]  exp_err;
   logic [7:0]  mm [3][512];

   dmem_hs #(.DW(32), .DEPTH(64), .AW(32), .WAIT(0)) u_w0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0][31:0]), .rsp_valid(rsp_valid[0]),
      .rsp_ready(rsp_ready[0]), .rsp_rdata(rd0), .rsp_err(rsp_err[0]));

   dmem_hs #(.DW(64), .DEPTH(64), .AW(32), .WAIT(3)) u_w3 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
      .rsp_ready(rsp_ready[1]), .rsp_rdata(rd1), .rsp_err(rsp_err[1]));

   dmem_hs #(.DW(32), .DEPTH(64), .AW(32), .WAIT(2)) u_w2 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_we(req_we[2]), .req_size(req_size[2]), .req_unsigned(req_unsigned[2]),
      .req_addr(req_addr[2]), .req_wdata(req_wdata[2][31:0]), .rsp_valid(rsp_valid[2]),
      .rsp_ready(rsp_ready[2]), .rsp_rdata(rd2), .rsp_err(rsp_err[2]));

   function automatic logic [63:0] rdv(input int i);
      case (i)
         0:       return {32'b0, rd0};
         1:       return rd1;
         default: return {32'b0, rd2};
      endcase
   endfunction

   // the access of a request falls on edge accept+WAIT, using the accepted request
   function automatic logic go_m(input int i);
      return (ph[i] == 0 && req_valid[i] && WTV[i] == 0) || (ph[i] == 1 && rem[i] == 1);
   endfunction
   function automatic logic m_we(input int i);
      return (ph[i] == 0) ? req_we[i] : l_we[i];
   endfunction
   function automatic logic m_uns(input int i);
      return (ph[i] == 0) ? req_unsigned[i] : l_uns[i];
   endfunction
   function automatic logic [1:0] m_size(input int i);
      return (ph[i] == 0) ? req_size[i] : l_size[i];
   endfunction
   function automatic int m_addr(input int i);
      return (ph[i] == 0) ? int'(req_addr[i]) : int'(l_addr[i]);
   endfunction
   function automatic logic [7:0] m_byte(input int i, input int k);
      logic [63:0] w;
      w = (ph[i] == 0) ? req_wdata[i] : l_wdata[i];
      return w[8*k +: 8];
   endfunction
   function automatic logic m_err(input int i);
      int nb, bpw, a;
      nb = 1 << m_size(i);
      bpw = DWV[i] / 8;
      a = m_addr(i);
      return (nb > bpw) || (a % nb != 0) || (a / bpw >= 64);
   endfunction
   function automatic logic [63:0] m_load(input int i);
      int nb, a;
      logic [63:0] v;
      nb = 1 << m_size(i);
      a = m_addr(i);
      v = '0;
      for (int k = 0; k < nb; k++) v[8*k +: 8] = mm[i][a+k];
      if (!m_uns(i) && 8*nb < DWV[i] && v[8*nb-1]) begin
         for (int b = 8*nb; b < DWV[i]; b++) v[b] = 1'b1;
      end
      return v;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) ph[i] <= 0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (go_m(i)) begin
               exp_err[i] <= m_err(i);
               exp_rd[i]  <= (m_err(i) || m_we(i)) ? 64'd0 : m_load(i);
               if (m_we(i) && !m_err(i)) begin
                  for (int k = 0; k < (1 << m_size(i)); k++) mm[i][m_addr(i)+k] <= m_byte(i, k);
               end
            end
            case (ph[i])
               0: if (req_valid[i]) begin
                     l_we[i]    <= req_we[i];
                     l_uns[i]   <= req_unsigned[i];
                     l_size[i]  <= req_size[i];
                     l_addr[i]  <= req_addr[i];
                     l_wdata[i] <= req_wdata[i];
                     rem[i]     <= WTV[i];
                     ph[i]      <= (WTV[i] == 0) ? 2 : 1;
                  end
               1: begin
                     rem[i] <= rem[i] - 1;
                     if (rem[i] == 1) ph[i] <= 2;
                  end
               2: if (rsp_ready[i]) ph[i] <= 0;
               default: ph[i] <= 0;
            endcase
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("req_ready[%0d]", i), 64'(req_ready[i]), 64'(ph[i] == 0));
         chk($sformatf("rsp_valid[%0d]", i), 64'(rsp_valid[i]), 64'(ph[i] == 2));
         if (ph[i] == 2) begin
            chk($sformatf("rsp_rdata[%0d]", i), rdv(i), exp_rd[i]);
            chk($sformatf("rsp_err[%0d]", i), 64'(rsp_err[i]), 64'(exp_err[i]));
         end
      end
   end

   task automatic txn(input int i, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [63:0] wd, input int hold,
                      output logic [63:0] rd, output logic er, output int lat);
      @(negedge clk);
      req_valid[i] = 1'b1;
      req_we[i] = we;
      req_size[i] = sz;
      req_unsigned[i] = uns;
      req_addr[i] = a;
      req_wdata[i] = wd;
      rsp_ready[i] = 1'b0;
      @(negedge clk);
      // scrambled inputs after accept must not matter
      req_valid[i] = 1'b0;
      req_we[i] = ~we;
      req_size[i] = ~sz;
      req_unsigned[i] = ~uns;
      req_addr[i] = a ^ 32'h0000_0044;
      req_wdata[i] = ~wd;
      lat = 0;
      while (!rsp_valid[i] && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (!rsp_valid[i]) begin
         failures++;
         $display("FAIL timeout[%0d]: rsp_valid=0 after %0d cycles, required 1", i, lat);
      end
      rd = rdv(i);
      er = rsp_err[i];
      repeat (hold) @(negedge clk);
      rsp_ready[i] = 1'b1;
      @(negedge clk);
      rsp_ready[i] = 1'b0;
   endtask

   task automatic xact(input int i, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [63:0] wd, input int hold,
                       input string nm, input logic [63:0] erd, input logic eer);
      logic [63:0] rd;
      logic er;
      int lat;
      txn(i, we, sz, uns, a, wd, hold, rd, er, lat);
      $display("txn %s inst=%0d we=%0d size=%0d addr=0x%0h rdata=0x%0h err=%0d lat=%0d",
               nm, i, we, sz, a, rd, er, lat);
      chk({nm, "_rdata"}, rd, erd);
      chk({nm, "_err"}, 64'(er), 64'(eer));
      chk({nm, "_lat"}, 64'(lat), 64'(WTV[i]));
   endtask

   initial begin
      req_valid = '0;
      req_we = '0;
      req_unsigned = '0;
      rsp_ready = '0;
      for (int i = 0; i < 3; i++) begin
         req_size[i] = 2'd0;
         req_addr[i] = 32'd0;
         req_wdata[i] = 64'd0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_rdata%0d", i), rdv(i), 64'd0);
         chk($sformatf("rst_err%0d", i), 64'(rsp_err[i]), 64'd0);
         chk($sformatf("rst_valid%0d", i), 64'(rsp_valid[i]), 64'd0);
      end
      rst_n = 1'b1;
      chk("rel_ready0", 64'(req_ready[0]), 64'd1);

      // 32-bit, no wait states
      xact(0, 1, 2'd2, 0, 32'h10, 64'hDEADBEEF, 0, "st_w10", 64'd0, 0);
      xact(0, 0, 2'd2, 0, 32'h10, 64'd0, 0, "ld_w10", 64'hDEADBEEF, 0);
      xact(0, 1, 2'd0, 0, 32'h11, 64'h80, 0, "st_b11", 64'd0, 0);
      xact(0, 0, 2'd2, 0, 32'h10, 64'd0, 0, "ld_w10b", 64'hDEAD80EF, 0);
      xact(0, 0, 2'd0, 0, 32'h11, 64'd0, 0, "ld_bs11", 64'hFFFFFF80, 0);
      xact(0, 0, 2'd0, 1, 32'h11, 64'd0, 0, "ld_bu11", 64'h00000080, 0);
      xact(0, 0, 2'd1, 0, 32'h12, 64'd0, 0, "ld_hs12", 64'hFFFFDEAD, 0);
      xact(0, 0, 2'd1, 1, 32'h10, 64'd0, 0, "ld_hu10", 64'h000080EF, 0);
      xact(0, 0, 2'd1, 0, 32'h13, 64'd0, 0, "ld_h13_mis", 64'd0, 1);
      xact(0, 1, 2'd2, 0, 32'h12, 64'hCAFEF00D, 0, "st_w12_mis", 64'd0, 1);
      xact(0, 0, 2'd3, 0, 32'h10, 64'd0, 0, "ld_d_illegal", 64'd0, 1);
      xact(0, 0, 2'd2, 0, 32'h10, 64'd0, 0, "ld_w10_kept", 64'hDEAD80EF, 0);
      xact(0, 0, 2'd2, 0, 32'h100, 64'd0, 0, "ld_w100_oor", 64'd0, 1);
      xact(0, 1, 2'd2, 0, 32'hFC, 64'h76543210, 0, "st_wFC", 64'd0, 0);
      xact(0, 0, 2'd1, 0, 32'hFE, 64'd0, 0, "ld_hsFE", 64'h00007654, 0);

      // 64-bit, 3 wait states
      xact(1, 1, 2'd3, 0, 32'h8, 64'h0123456789ABCDEF, 0, "st_d08", 64'd0, 0);
      xact(1, 0, 2'd1, 0, 32'hE, 64'd0, 0, "ld_h0E", 64'h0000000000000123, 0);
      xact(1, 0, 2'd3, 1, 32'h8, 64'd0, 0, "ld_d08", 64'h0123456789ABCDEF, 0);
      xact(1, 0, 2'd2, 0, 32'hC, 64'd0, 0, "ld_ws0C", 64'h0000000001234567, 0);
      xact(1, 0, 2'd2, 0, 32'h8, 64'd0, 0, "ld_ws08", 64'hFFFFFFFF89ABCDEF, 0);
      xact(1, 0, 2'd0, 1, 32'h9, 64'd0, 0, "ld_bu09", 64'h00000000000000CD, 0);
      xact(1, 0, 2'd3, 0, 32'hC, 64'd0, 0, "ld_d0C_mis", 64'd0, 1);

      // 2 wait states, response held off by the consumer
      xact(2, 1, 2'd2, 0, 32'h4, 64'h5A5A1234, 5, "st_w04_hold", 64'd0, 0);
      xact(2, 0, 2'd2, 0, 32'h4, 64'd0, 5, "ld_w04_hold", 64'h5A5A1234, 0);
      chk("idle_after_hold", 64'(req_ready[2]), 64'd1);

      // reset while a store waits: never written
      xact(2, 1, 2'd2, 0, 32'h20, 64'h11111111, 0, "st_w20_old", 64'd0, 0);
      xact(2, 0, 2'd2, 0, 32'h20, 64'd0, 0, "ld_w20_old", 64'h11111111, 0);
      @(negedge clk);
      req_valid[2] = 1'b1; req_we[2] = 1'b1; req_size[2] = 2'd2;
      req_addr[2] = 32'h20; req_wdata[2] = 64'h22222222;
      @(negedge clk);
      req_valid[2] = 1'b0;
      chk("wait_ready", 64'(req_ready[2]), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      $display("txn rst_in_wait ready=%0d valid=%0d rdata=0x%0h err=%0d",
               req_ready[2], rsp_valid[2], rdv(2), rsp_err[2]);
      chk("rstw_ready", 64'(req_ready[2]), 64'd1);
      chk("rstw_valid", 64'(rsp_valid[2]), 64'd0);
      chk("rstw_rdata", rdv(2), 64'd0);
      chk("rstw_err", 64'(rsp_err[2]), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      xact(2, 0, 2'd2, 0, 32'h20, 64'd0, 0, "ld_w20_after_wrst", 64'h11111111, 0);

      // reset while a store responds: already written
      @(negedge clk);
      req_valid[2] = 1'b1; req_we[2] = 1'b1; req_size[2] = 2'd2;
      req_addr[2] = 32'h20; req_wdata[2] = 64'h33333333;
      @(negedge clk);
      req_valid[2] = 1'b0;
      for (int n = 0; n < 20 && !rsp_valid[2]; n++) @(negedge clk);
      chk("resp_reached", 64'(rsp_valid[2]), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      $display("txn rst_in_resp ready=%0d valid=%0d err=%0d", req_ready[2], rsp_valid[2], rsp_err[2]);
      chk("rstr_valid", 64'(rsp_valid[2]), 64'd0);
      chk("rstr_ready", 64'(req_ready[2]), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      xact(2, 0, 2'd2, 0, 32'h20, 64'd0, 0, "ld_w20_after_rrst", 64'h33333333, 0);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
